// File: rtl/interleave_pkg.sv
// Shared constants for the interleave latency monitor: controller state codes
// and the latency-field width helper.
package interleave_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_MEASURE = 2'd1;
   localparam state_t ST_REPORT  = 2'd2;

   // Bits needed to hold a latency of 0..t cycles.
   function automatic int lat_w(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/interleave_latency_monitor_if.sv
// Stimulus/observation bus and result handshake of the interleave latency monitor.
// The monitor takes the slave side; the stimulus generator / result consumer the master side.
interface interleave_latency_monitor_if #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 4,
   parameter int TIMEOUT  = 15
);
   import interleave_pkg::*;

   localparam int LAT_W = lat_w(TIMEOUT);

   logic [WIDTH-1:0]          stim;
   logic [CHANNELS*WIDTH-1:0] obs;
   logic [CHANNELS-1:0]       inv;
   logic                      busy;
   logic                      change_drop;
   logic                      res_valid;
   logic                      res_ready;
   logic [CHANNELS*LAT_W-1:0] res_lat;
   logic [CHANNELS-1:0]       res_timeout;

   modport master (
      output stim, obs, inv, res_ready,
      input  busy, change_drop, res_valid, res_lat, res_timeout
   );

   modport slave (
      input  stim, obs, inv, res_ready,
      output busy, change_drop, res_valid, res_lat, res_timeout
   );

endinterface

// File: rtl/interleave_lane.sv
// One observed channel: polarity-aware match, sticky done flag, latency and timeout capture.
// Results update only on the controller's start / measure strobes and hold otherwise.
module interleave_lane #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15,
   parameter int LAT_W   = interleave_pkg::lat_w(TIMEOUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             meas_i,
   input  logic             tmo_i,
   input  logic             inv_i,
   input  logic [WIDTH-1:0] ref_i,
   input  logic [WIDTH-1:0] obs_i,
   input  logic [LAT_W-1:0] cnt_i,
   output logic             done_nxt_o,
   output logic [LAT_W-1:0] lat_o,
   output logic             timeout_o
);

   localparam logic [LAT_W-1:0] TMO_LAT = LAT_W'(TIMEOUT);

   logic [WIDTH-1:0] exp_val;
   logic             match;
   logic             done_q, done_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             to_q, to_d;

   assign exp_val = inv_i ? ~ref_i : ref_i;
   // X/Z on the observed word makes this X, which the if below treats as no match.
   assign match   = (obs_i == exp_val);

   always_comb begin
      done_d = done_q;
      lat_d  = lat_q;
      to_d   = to_q;
      if (start_i) begin
         done_d = match;
         lat_d  = '0;
         to_d   = 1'b0;
      end else if (meas_i && !done_q) begin
         if (match) begin
            done_d = 1'b1;
            lat_d  = cnt_i;
         end else if (tmo_i) begin
            to_d   = 1'b1;
            lat_d  = TMO_LAT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
         lat_q  <= '0;
         to_q   <= 1'b0;
      end else begin
         done_q <= done_d;
         lat_q  <= lat_d;
         to_q   <= to_d;
      end
   end

   assign done_nxt_o = done_d;
   assign lat_o      = lat_q;
   assign timeout_o  = to_q;

endmodule

// File: rtl/interleave_latency_monitor.sv
// Measures per-channel cycles from a stim change to each channel reflecting it; result in 1..TIMEOUT+1 cycles.
// Result is held with res_valid until res_ready; stim changes while busy are dropped and flagged.
module interleave_latency_monitor #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic                            clk,
   input  logic                            rst,
   interleave_latency_monitor_if.slave     mon
);
   import interleave_pkg::*;

   localparam int               LAT_W   = lat_w(TIMEOUT);
   localparam logic [LAT_W-1:0] TMO_CNT = LAT_W'(TIMEOUT);

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    stim_q;
   logic [WIDTH-1:0]    target_q, target_d;
   logic [LAT_W-1:0]    cnt_q, cnt_d;
   logic [CHANNELS-1:0] done_nxt;
   logic [WIDTH-1:0]    ref_val;
   logic                change, in_idle, in_meas, start, tmo_edge, all_done_nxt;

   assign change       = (mon.stim != stim_q);
   assign in_idle      = (state_q == ST_IDLE);
   assign in_meas      = (state_q == ST_MEASURE);
   assign start        = in_idle && change;
   assign tmo_edge     = in_meas && (cnt_q == TMO_CNT);
   assign all_done_nxt = &done_nxt;
   // The start edge compares against the live stim; target_q only exists from the next cycle.
   assign ref_val      = in_idle ? mon.stim : target_q;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (change) begin
               target_d = mon.stim;
               cnt_d    = LAT_W'(1);
               state_d  = all_done_nxt ? ST_REPORT : ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (all_done_nxt || tmo_edge) begin
               state_d = ST_REPORT;
            end else begin
               cnt_d = cnt_q + LAT_W'(1);
            end
         end
         ST_REPORT: begin
            if (mon.res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         stim_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         stim_q   <= mon.stim;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      interleave_lane #(
         .WIDTH   (WIDTH),
         .TIMEOUT (TIMEOUT),
         .LAT_W   (LAT_W)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .start_i    (start),
         .meas_i     (in_meas),
         .tmo_i      (tmo_edge),
         .inv_i      (mon.inv[k]),
         .ref_i      (ref_val),
         .obs_i      (mon.obs[k*WIDTH +: WIDTH]),
         .cnt_i      (cnt_q),
         .done_nxt_o (done_nxt[k]),
         .lat_o      (mon.res_lat[k*LAT_W +: LAT_W]),
         .timeout_o  (mon.res_timeout[k])
      );
   end

   assign mon.busy        = !in_idle;
   assign mon.change_drop = !in_idle && change;
   assign mon.res_valid   = (state_q == ST_REPORT);

   // A pending result must not vanish or change until the consumer takes it.
   a_res_hold : assert property (@(posedge clk) disable iff (rst)
      (mon.res_valid && !mon.res_ready) |=>
         (mon.res_valid && $stable(mon.res_lat) && $stable(mon.res_timeout)));

endmodule

// File: tb/tb_interleave_latency_monitor.sv
// Directed and randomized bench for interleave_latency_monitor against an edge-indexed reference model.
module tb_interleave_latency_monitor;

   localparam int CH = 4;
   localparam int W  = 4;
   localparam int TO = 7;
   localparam int LW = interleave_pkg::lat_w(TO);

   logic clk = 1'b0;
   logic rst = 1'b0;

   interleave_latency_monitor_if #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TO)) bus ();

   interleave_latency_monitor #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus environment: channel k shows stim delayed dly[k] cycles (0 = same cycle),
   // -1 = stuck at zero, 5 = alternates correct / wrong every cycle.
   logic [W-1:0]  t_stim = '0;
   logic          t_rdy  = 1'b0;
   logic [CH-1:0] t_inv  = '0;
   int            dly [CH];
   logic [W-1:0]  hist [8];
   int            cyc = 0;

   function automatic logic [W-1:0] chan_obs(input int k);
      logic [W-1:0] base;
      if (dly[k] < 0) return '0;
      if (dly[k] == 5) base = (cyc % 2 == 1) ? hist[0] : ~hist[0];
      else             base = hist[dly[k]];
      return t_inv[k] ? ~base : base;
   endfunction

   task automatic apply();
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t_stim;
      cyc++;
      bus.stim      = t_stim;
      bus.inv       = t_inv;
      bus.res_ready = t_rdy;
      for (int k = 0; k < CH; k++) bus.obs[k*W +: W] = chan_obs(k);
   endtask

   // Reference model: a measurement is a window of edges opened by an idle change;
   // m_first[k] is the index (edges after the opening edge) of channel k's first match.
   logic [W-1:0] m_prev = '0;
   logic [W-1:0] m_tgt  = '0;
   bit           m_act  = 1'b0;
   bit           m_rep  = 1'b0;
   int           m_first [CH];
   int           ecount = 0;
   int           m_e0   = 0;

   function automatic bit ch_match(input int k);
      logic [W-1:0] e;
      e = t_inv[k] ? ~m_tgt : m_tgt;
      return bus.obs[k*W +: W] === e;
   endfunction

   function automatic bit all_found();
      for (int k = 0; k < CH; k++) if (m_first[k] < 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      m_act  = 1'b0;
      m_rep  = 1'b0;
      m_prev = '0;
   endtask

   task automatic model_step();
      int j;
      if (m_rep) begin
         if (t_rdy) m_rep = 1'b0;
      end else if (m_act) begin
         j = ecount - m_e0;
         for (int k = 0; k < CH; k++) if (m_first[k] < 0 && ch_match(k)) m_first[k] = j;
         if (all_found() || j == TO) begin
            m_act = 1'b0;
            m_rep = 1'b1;
         end
      end else if (t_stim != m_prev) begin
         m_e0  = ecount;
         m_tgt = t_stim;
         for (int k = 0; k < CH; k++) m_first[k] = ch_match(k) ? 0 : -1;
         if (all_found()) m_rep = 1'b1;
         else             m_act = 1'b1;
      end
      m_prev = t_stim;
      ecount++;
   endtask

   task automatic check_outputs();
      check_eq("busy",  32'(bus.busy),        32'(m_act | m_rep));
      check_eq("valid", 32'(bus.res_valid),   32'(m_rep));
      check_eq("drop",  32'(bus.change_drop), 32'((m_act | m_rep) && (t_stim != m_prev)));
      if (m_rep) begin
         for (int k = 0; k < CH; k++) begin
            check_eq($sformatf("lat%0d", k), 32'(bus.res_lat[k*LW +: LW]),
                     32'((m_first[k] >= 0) ? m_first[k] : TO));
            check_eq($sformatf("to%0d", k), 32'(bus.res_timeout[k]), 32'(m_first[k] < 0));
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      apply();
      @(negedge clk);
      check_outputs();
      model_step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_eq("rst_busy",  32'(bus.busy),        32'd0);
      check_eq("rst_valid", 32'(bus.res_valid),   32'd0);
      check_eq("rst_drop",  32'(bus.change_drop), 32'd0);
      check_eq("rst_lat",   32'(bus.res_lat),     32'd0);
      check_eq("rst_to",    32'(bus.res_timeout), 32'd0);
      model_clear();
      repeat (3) begin
         @(posedge clk);
         #1;
         apply();
      end
      @(negedge clk);
      rst = 1'b0;
      model_step();
   endtask

   task automatic wait_rep(output int n, input int budget);
      n = 0;
      while (!m_rep && n < budget) begin
         cycle();
         n++;
      end
      if (!m_rep) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_rep no result within %0d cycles", budget);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int drops;
      for (int i = 0; i < 8; i++) hist[i] = '0;
      for (int k = 0; k < CH; k++) dly[k] = 0;
      apply();
      #1;
      rst = 1'b1;
      #1;
      check_eq("por_busy",  32'(bus.busy),        32'd0);
      check_eq("por_valid", 32'(bus.res_valid),   32'd0);
      check_eq("por_lat",   32'(bus.res_lat),     32'd0);
      check_eq("por_to",    32'(bus.res_timeout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      model_step();
      repeat (3) cycle();

      // Mixed drivers: buf, not, one register, three registers.
      dly[0] = 0; dly[1] = 0; dly[2] = 1; dly[3] = 3;
      t_inv  = 4'b0010;
      cycle();
      t_stim = 4'h5;
      wait_rep(n, 20);
      check_eq("t1_edges", 32'(n), 32'd4);
      cycle();
      check_eq("t1_lat", 32'(bus.res_lat),     32'h640);
      check_eq("t1_to",  32'(bus.res_timeout), 32'h0);
      t_rdy  = 1'b1;
      t_stim = 4'h0;
      repeat (12) cycle();

      // Channel 3 never responds.
      t_rdy  = 1'b0;
      dly[3] = -1;
      cycle();
      t_stim = 4'hA;
      wait_rep(n, 20);
      check_eq("t2_edges", 32'(n), 32'd8);
      cycle();
      check_eq("t2_lat", 32'(bus.res_lat),     32'hE40);
      check_eq("t2_to",  32'(bus.res_timeout), 32'h8);

      // Consumer stalls; a stim change meanwhile is dropped.
      drops = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) t_stim = 4'h3;
         cycle();
         drops += int'(bus.change_drop);
      end
      check_eq("t4_drops",    32'(drops),          32'd1);
      check_eq("t4_lat_hold", 32'(bus.res_lat),    32'hE40);
      check_eq("t4_vld_hold", 32'(bus.res_valid),  32'd1);
      t_rdy = 1'b1;
      cycle();
      t_rdy = 1'b0;
      repeat (2) cycle();
      check_eq("t4_no_restart", 32'(bus.busy), 32'd0);

      // All combinational: result right after the opening edge.
      for (int k = 0; k < CH; k++) dly[k] = 0;
      t_inv = 4'b1010;
      cycle();
      t_stim = 4'hF;
      wait_rep(n, 20);
      check_eq("t3_edges", 32'(n), 32'd1);
      cycle();
      check_eq("t3_lat", 32'(bus.res_lat),     32'h0);
      check_eq("t3_to",  32'(bus.res_timeout), 32'h0);
      t_rdy = 1'b1;
      cycle();
      t_rdy = 1'b0;

      // Reset in the middle of a measurement.
      for (int k = 0; k < CH; k++) dly[k] = 4;
      t_inv = 4'b0000;
      cycle();
      t_stim = 4'h6;
      repeat (2) cycle();
      check_eq("t5_busy_pre", 32'(bus.busy), 32'd1);
      do_reset();
      wait_rep(n, 20);
      cycle();
      check_eq("t5_lat", 32'(bus.res_lat), 32'h0);
      t_rdy = 1'b1;
      cycle();
      t_rdy = 1'b0;

      // Channel 0 matches then diverges; its first match must stick.
      dly[0] = 5; dly[1] = 2; dly[2] = 2; dly[3] = 2;
      cycle();
      t_stim = 4'h9;
      wait_rep(n, 20);
      cycle();
      check_eq("t6_to0", 32'(bus.res_timeout[0]), 32'd0);
      t_rdy = 1'b1;
      cycle();

      // Randomized traffic.
      for (int it = 0; it < 1500; it++) begin
         if (!m_act && !m_rep && ($urandom % 8 == 0)) begin
            t_inv = CH'($urandom);
            for (int k = 0; k < CH; k++) dly[k] = int'($urandom_range(0, 6)) - 1;
         end
         if ($urandom % 4 == 0) t_stim = W'($urandom);
         t_rdy = ($urandom % 3 != 0);
         if ($urandom % 400 == 0) do_reset();
         else                     cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/interleave_latency_monitor.md
# interleave_latency_monitor

Synthesizable, parametrised monitor that measures in clock cycles how long each of N observed channels takes to reflect a change on a shared stimulus word. It generalises the single-bit buf/not propagation experiments to WIDTH-bit stimulus, CHANNELS observers with per-channel polarity, and a bounded timeout. Results are returned through a valid/ready handshake. It sits beside a device under test in the interleave test benches and bins each driver style into zero-cycle, registered or timed-out.

## Interface
- CHANNELS, 8, number of observed channels (≥1)
- WIDTH, 4, stimulus/observation width in bits (≥1)
- TIMEOUT, 15, maximum measured latency in cycles (≥1); LAT_W = $clog2(TIMEOUT+1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stim  in  WIDTH  stimulus word
- obs  in  CHANNELS*WIDTH  observed values; channel k at [k*WIDTH +: WIDTH]
- inv  in  CHANNELS  bit k set: channel k expects ~stim (not gate), else stim (buf)
- busy  out  1  high in MEASURE or REPORT
- change_drop  out  1  one-cycle pulse: stim changed while busy
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_lat  out  CHANNELS*LAT_W  per-channel latency; channel k at [k*LAT_W +: LAT_W]
- res_timeout  out  CHANNELS  per-channel timeout flag

## Operation
- stim_q registers stim every cycle; change = (stim != stim_q).
- States: IDLE, MEASURE, REPORT.
- IDLE, change at edge E0: target <= stim; exp_k = inv[k] ? ~target : target; cnt <= 1; channels whose sampled obs_k == exp_k marked done with lat 0. All done -> REPORT, else MEASURE.
- MEASURE, each edge: each not-done channel matching exp_k -> done, lat_k = cnt. Match is sticky; later divergence ignored. cnt increments. All done -> REPORT. cnt == TIMEOUT and not all done -> undone channels get timeout=1, lat=TIMEOUT; -> REPORT.
- Channels that match at the timeout edge count as done (timeout=0, lat=TIMEOUT).
- REPORT: res_valid=1, res_lat/res_timeout stable. res_valid & res_ready at an edge -> IDLE.
- change while busy: no restart; target unchanged; change_drop pulses that cycle. stim_q keeps tracking, so a value settled during busy is not re-detected in IDLE.
- Comparison is 4-state-free (==); X on obs counts as no match.

## Timing
- Reset (async assert): state IDLE, stim_q=0, cnt=0, busy=0, change_drop=0, res_valid=0, res_lat=0, res_timeout=0. Reset mid-MEASURE/REPORT discards the result.
- Latency 0 = obs already correct when change is sampled (same-cycle propagation); 1 = one register stage.
- res_valid rises the cycle after the completing edge; earliest is one cycle after E0.
- res_valid never drops without res_ready; earliest next measurement starts on the edge after acceptance.
- Worst-case measurement: TIMEOUT+1 edges from E0 to REPORT.

## Structure
- Package interleave_pkg: state enum (IDLE, MEASURE, REPORT), lat_w function ($clog2(t+1)).
- Sub-module interleave_lane, instantiated CHANNELS times: done flag, lat and timeout registers, match compare with polarity; controller shared at top.

## Test plan
- CHANNELS=4, WIDTH=4, TIMEOUT=7, inv=0010; obs0 = stim comb, obs1 = ~stim comb, obs2 = stim delayed 1 reg, obs3 = stim delayed 3 regs; stim 0→5 -> lats 0,0,1,3, timeouts 0000.
- obs3 tied to 0, stim 0→A -> lat3=7, timeout3=1, others as above; REPORT after 8 edges.
- All channels combinational, stim 0→F -> res_valid the cycle after E0, all lats 0.
- Hold res_ready=0 for 5 cycles in REPORT -> res_valid and data stable; stim change meanwhile -> change_drop pulses, no new measurement.
- Assert rst in MEASURE -> res_valid=0, busy=0 immediately; next stim change measures from scratch.
- obs0 matches then diverges -> lat0 keeps first match cycle, timeout0=0.
